// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Byte lanes are listed in big-endian write order.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        WRITE,
        DONE
    } state_t;

    localparam int IMEM_SIZE_DEF = 4096;

    localparam logic [1:0] LANE_31_24 = 2'd0;
    localparam logic [1:0] LANE_23_16 = 2'd1;
    localparam logic [1:0] LANE_15_8  = 2'd2;
    localparam logic [1:0] LANE_7_0   = 2'd3;

endpackage

// File: rtl/imem_loader.sv
// Streams 32-bit words into byte-wide instruction memory, big-endian.
// Define IMEM_LOADER_BOUNDS_CHECK_EN to reject words beyond IMEM_SIZE.
module imem_loader
    import imem_pkg::*;
#(
    parameter int          IMEM_SIZE = IMEM_SIZE_DEF,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    input  logic        in_last,
    output logic        wr_en,
    output logic [63:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] word_count,
    output logic        err
);

    localparam logic [64:0] LIMIT = 65'(IMEM_SIZE);

    state_t      r_state;
    state_t      w_next;
    logic [63:0] r_ptr;
    logic [1:0]  r_idx;
    logic [31:0] r_word;
    logic        r_last;
    logic [31:0] r_count;
    logic        w_hs;
    logic        w_oob;
    logic        w_rej;
    logic [7:0]  w_byte;

    assign w_hs  = (r_state == ACCEPT) && in_valid;
    // 65-bit sum so a pointer near 2^64 cannot wrap into range
    assign w_oob = ({1'b0, r_ptr} + 65'd3) > (LIMIT - 65'd1);

`ifdef IMEM_LOADER_BOUNDS_CHECK_EN
    logic r_err;

    assign w_rej = w_oob;
    assign err   = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_err <= 1'b0;
        end else if (w_hs && w_oob) begin
            r_err <= 1'b1;
        end
    end
`else
    logic w_unused;

    assign w_rej    = 1'b0;
    assign err      = 1'b0;
    assign w_unused = w_oob;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_word  <= '0;
            r_last  <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ptr   <= BASE_ADDR;
                        r_count <= '0;
                    end
                end
                ACCEPT: begin
                    if (w_hs) begin
                        r_word <= in_word;
                        r_last <= in_last;
                        r_idx  <= '0;
                    end
                end
                WRITE: begin
                    r_ptr <= r_ptr + 64'd1;
                    r_idx <= r_idx + 2'd1;
                    if (r_idx == LANE_7_0) begin
                        r_count <= r_count + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = ACCEPT;
            ACCEPT:  if (w_hs) w_next = w_rej ? DONE : WRITE;
            WRITE: begin
                if (r_idx == LANE_7_0) begin
                    w_next = r_last ? DONE : ACCEPT;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_byte = r_word[7:0];
        unique case (r_idx)
            LANE_31_24: w_byte = r_word[31:24];
            LANE_23_16: w_byte = r_word[23:16];
            LANE_15_8:  w_byte = r_word[15:8];
            LANE_7_0:   w_byte = r_word[7:0];
            default:    w_byte = r_word[7:0];
        endcase
    end

    always_comb begin
        in_ready = (r_state == ACCEPT);
        wr_en    = (r_state == WRITE);
        busy     = (r_state != IDLE);
        done     = (r_state == DONE);
        wr_addr  = wr_en ? r_ptr : 64'd0;
        wr_data  = wr_en ? w_byte : 8'd0;
    end

    assign word_count = r_count;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: default-size instance plus an
// IMEM_SIZE=8 instance exercising the optional range check.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [31:0] in_word;
    logic        in_last;

    logic        rdy1, wen1, busy1, done1, err1;
    logic [63:0] addr1;
    logic [7:0]  data1;
    logic [31:0] cnt1;

    logic        rdy2, wen2, busy2, done2, err2;
    logic [63:0] addr2;
    logic [7:0]  data2;
    logic [31:0] cnt2;

    int n_chk  = 0;
    int n_fail = 0;
    int n1 = 0;
    int n2 = 0;
    logic [63:0] la [256];
    logic [7:0]  ld [256];

`ifdef IMEM_LOADER_BOUNDS_CHECK_EN
    localparam int   EXP_W2  = 8;
    localparam int   EXP_CNT = 2;
    localparam int   EXP_DC  = 12;
    localparam logic EXP_ERR = 1'b1;
`else
    localparam int   EXP_W2  = 12;
    localparam int   EXP_CNT = 3;
    localparam int   EXP_DC  = 16;
    localparam logic EXP_ERR = 1'b0;
`endif

    localparam logic [31:0] WA = 32'h00500093;
    localparam logic [31:0] WB = 32'h00A00113;
    localparam logic [31:0] WC = 32'h002081B3;

    always #5 clk = ~clk;

    imem_loader dut1 (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(rdy1),
        .in_word(in_word), .in_last(in_last),
        .wr_en(wen1), .wr_addr(addr1), .wr_data(data1),
        .busy(busy1), .done(done1),
        .word_count(cnt1), .err(err1)
    );

    imem_loader #(.IMEM_SIZE(8)) dut2 (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(rdy2),
        .in_word(in_word), .in_last(in_last),
        .wr_en(wen2), .wr_addr(addr2), .wr_data(data2),
        .busy(busy2), .done(done2),
        .word_count(cnt2), .err(err2)
    );

    always @(negedge clk) begin
        if (wen1 === 1'b1) begin
            la[n1 % 256] = addr1;
            ld[n1 % 256] = data1;
            n1++;
        end
        if (wen2 === 1'b1) n2++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int base;
        int dcyc;
        logic [7:0] ba [4];
        ba[0] = 8'h00; ba[1] = 8'h50; ba[2] = 8'h00; ba[3] = 8'h93;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        in_word = '0; in_last = 1'b0;
        step(); step();
        check("rst_in_ready", 64'(rdy1), 64'd0);
        check("rst_wr_en", 64'(wen1), 64'd0);
        check("rst_wr_addr", addr1, 64'd0);
        check("rst_wr_data", 64'(data1), 64'd0);
        check("rst_busy", 64'(busy1), 64'd0);
        check("rst_done", 64'(done1), 64'd0);
        check("rst_word_count", 64'(cnt1), 64'd0);
        check("rst_err", 64'(err1), 64'd0);
        rst = 1'b0;
        step();

        // single word
        base = n1;
        start = 1'b1; in_valid = 1'b1; in_word = WA; in_last = 1'b1;
        step();
        start = 1'b0;
        check("s1_in_ready", 64'(rdy1), 64'd1);
        step();
        in_valid = 1'b0; in_word = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            check("s1_wr_en", 64'(wen1), 64'd1);
            check("s1_wr_addr", addr1, 64'(i));
            check("s1_wr_data", 64'(data1), 64'(ba[i]));
            step();
        end
        check("s1_done", 64'(done1), 64'd1);
        check("s1_wr_en_off", 64'(wen1), 64'd0);
        check("s1_word_count", 64'(cnt1), 64'd1);
        step();
        check("s1_done_pulse", 64'(done1), 64'd0);
        check("s1_idle_busy", 64'(busy1), 64'd0);
        check("s1_nwrites", 64'(n1 - base), 64'd4);

        // three words back-to-back
        base = n1;
        start = 1'b1; in_valid = 1'b1; in_word = WA; in_last = 1'b0;
        step();
        start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            if (c == 1 || c == 6 || c == 11)
                check("s3_in_ready_hi", 64'(rdy1), 64'd1);
            if (c == 2 || c == 7)
                check("s3_in_ready_lo", 64'(rdy1), 64'd0);
            if (c == 16) begin
                check("s3_done", 64'(done1), 64'd1);
                check("s3_word_count", 64'(cnt1), 64'd3);
            end
            step();
            if (c == 1) in_word = WB;
            if (c == 6) begin
                in_word = WC; in_last = 1'b1;
            end
            if (c == 11) in_valid = 1'b0;
        end
        check("s3_nwrites", 64'(n1 - base), 64'd12);
        check("s3_addr0", la[base % 256], 64'd0);
        check("s3_addr11", la[(base + 11) % 256], 64'd11);
        check("s3_data4", 64'(ld[(base + 4) % 256]), 64'h00);
        check("s3_data5", 64'(ld[(base + 5) % 256]), 64'hA0);
        check("s3_data10", 64'(ld[(base + 10) % 256]), 64'h81);
        check("s3_data11", 64'(ld[(base + 11) % 256]), 64'hB3);

        // stall in ACCEPT
        start = 1'b1; in_valid = 1'b0; in_word = WA; in_last = 1'b1;
        step();
        start = 1'b0;
        base = n1;
        for (int i = 0; i < 3; i++) begin
            check("st_in_ready", 64'(rdy1), 64'd1);
            check("st_wr_en", 64'(wen1), 64'd0);
            step();
        end
        check("st_nwrites", 64'(n1 - base), 64'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("st_write_addr0", addr1, 64'd0);
        repeat (4) step();
        check("st_word_count", 64'(cnt1), 64'd1);
        step();

        // reset mid-word
        start = 1'b1; in_valid = 1'b1; in_word = 32'h11223344; in_last = 1'b1;
        step();
        start = 1'b0;
        step();
        in_valid = 1'b0;
        check("rm_byte0", 64'(data1), 64'h11);
        step();
        check("rm_byte1", 64'(data1), 64'h22);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rm_wr_en", 64'(wen1), 64'd0);
        check("rm_busy", 64'(busy1), 64'd0);
        start = 1'b1; in_valid = 1'b1; in_word = WA; in_last = 1'b1;
        step();
        start = 1'b0;
        step();
        in_valid = 1'b0;
        check("rm_restart_addr", addr1, 64'd0);
        check("rm_restart_data", 64'(data1), 64'h00);
        repeat (5) step();

        // start during WRITE is ignored
        base = n1;
        start = 1'b1; in_valid = 1'b1; in_word = WB; in_last = 1'b1;
        step();
        start = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("sw_addr2", addr1, 64'd2);
        check("sw_data2", 64'(data1), 64'h01);
        step();
        check("sw_addr3", addr1, 64'd3);
        step();
        check("sw_done", 64'(done1), 64'd1);
        step();
        check("sw_idle", 64'(busy1), 64'd0);
        check("sw_nwrites", 64'(n1 - base), 64'd4);

        // range check on the IMEM_SIZE=8 instance
        base = n2;
        dcyc = 0;
        start = 1'b1; in_valid = 1'b1; in_word = WA; in_last = 1'b0;
        step();
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (done2 === 1'b1 && dcyc == 0) dcyc = c;
            step();
            if (c == 1) in_word = WB;
            if (c == 6) begin
                in_word = WC; in_last = 1'b1;
            end
            if (c == 11) in_valid = 1'b0;
        end
        check("bc_nwrites", 64'(n2 - base), 64'(EXP_W2));
        check("bc_err", 64'(err2), 64'(EXP_ERR));
        check("bc_word_count", 64'(cnt2), 64'(EXP_CNT));
        check("bc_done_cycle", 64'(dcyc), 64'(EXP_DC));
        check("bc_busy", 64'(busy2), 64'd0);
        check("bc_big_err", 64'(err1), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
